// File: rtl/rowcache_ctrl_if.sv
// Bank-side request bus, cache RD/WR/RowId port and backing-store handshake
// of the row cache sequencer.
interface rowcache_ctrl_if #(
  parameter int NREQ      = 4,
  parameter int ADDRWIDTH = 17,
  parameter int CHWIDTH   = 5
);
  logic [NREQ-1:0]           req_rd;
  logic [NREQ-1:0]           req_wr;
  logic [NREQ*ADDRWIDTH-1:0] req_row;
  logic [NREQ-1:0]           req_done;
  logic                      RD;
  logic                      WR;
  logic [ADDRWIDTH-1:0]      RowId;
  logic                      hold;
  logic [CHWIDTH-1:0]        cRowId;
  logic [CHWIDTH-1:0]        last_slot;
  logic                      sync;
  logic                      mem_req;
  logic                      mem_wr;
  logic [ADDRWIDTH-1:0]      mem_row;
  logic                      mem_ack;
  logic                      mem_beat;

  modport slave (
    input  req_rd, req_wr, req_row, hold, cRowId, mem_ack, mem_beat,
    output req_done, RD, WR, RowId, last_slot, sync, mem_req, mem_wr, mem_row
  );

  modport master (
    output req_rd, req_wr, req_row, hold, cRowId, mem_ack, mem_beat,
    input  req_done, RD, WR, RowId, last_slot, sync, mem_req, mem_wr, mem_row
  );
endinterface

// File: rtl/rowcache_ctrl.sv
// Round-robin sequencer for the shared DRAM row cache with miss fill/writeback.
// Optional hit/miss counters are enabled by defining ROWCACHE_STATS_EN.
module rowcache_ctrl #(
  parameter int NREQ       = 4,
  parameter int ADDRWIDTH  = 17,
  parameter int CHWIDTH    = 5,
  parameter int ACC_CYCLES = 3,
  parameter int XFERBEATS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  rowcache_ctrl_if.slave   bus
`ifdef ROWCACHE_STATS_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam int IDXW = $clog2(NREQ);
  localparam int ACCW = $clog2(ACC_CYCLES + 1);
  localparam logic [ACCW-1:0] ACC_LAST  = ACCW'(ACC_CYCLES - 1);
  localparam logic [7:0]      BEAT_LAST = 8'(XFERBEATS - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE, ACCESS, MISS_REQ, MISS_XFER, SYNC, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [IDXW-1:0]       rr_q, rr_d;
  logic                  op_q, op_d;      // 1 = write
  logic [ADDRWIDTH-1:0]  row_q, row_d;
  logic [ACCW-1:0]       acc_q, acc_d;
  logic                  miss_q, miss_d;
  logic [7:0]            beat_q, beat_d;

  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [ADDRWIDTH-1:0]  rowid_q, rowid_d;
  logic                  sync_q, sync_d;
  logic                  mreq_q, mreq_d, mwr_q, mwr_d;
  logic [ADDRWIDTH-1:0]  mrow_q, mrow_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [CHWIDTH-1:0]    slot_q, slot_d;

  logic [NREQ-1:0]       pending;
  logic [IDXW-1:0]       cand;
  logic                  found;
  logic                  active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      op_q    <= 1'b0;
      row_q   <= '0;
      acc_q   <= '0;
      miss_q  <= 1'b0;
      beat_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rowid_q <= '0;
      sync_q  <= 1'b0;
      mreq_q  <= 1'b0;
      mwr_q   <= 1'b0;
      mrow_q  <= '0;
      done_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      miss_q  <= miss_d;
      beat_q  <= beat_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rowid_q <= rowid_d;
      sync_q  <= sync_d;
      mreq_q  <= mreq_d;
      mwr_q   <= mwr_d;
      mrow_q  <= mrow_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    op_d    = op_q;
    row_d   = row_q;
    acc_d   = acc_q;
    miss_d  = miss_q;
    beat_d  = beat_q;
    slot_d  = slot_q;
    pending = bus.req_rd | bus.req_wr;
    cand    = '0;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          cand = IDXW'((32'(rr_q) + k) % NREQ);
          if (!found && pending[cand]) begin
            found = 1'b1;
            idx_d = cand;
            op_d  = bus.req_wr[cand];
            row_d = bus.req_row[cand*ADDRWIDTH +: ADDRWIDTH];
            rr_d  = (cand == IDX_LAST) ? '0 : cand + 1'b1;
          end
        end
        if (found) begin
          state_d = ACCESS;
          acc_d   = '0;
          miss_d  = 1'b0;
        end
      end
      ACCESS: begin
        if (bus.hold) miss_d = 1'b1;
        if (acc_q == ACC_LAST) begin
          slot_d  = bus.cRowId;
          state_d = (miss_q || bus.hold) ? MISS_REQ : DONE;
        end else begin
          acc_d = acc_q + 1'b1;
        end
      end
      MISS_REQ: begin
        if (bus.mem_ack) begin
          state_d = MISS_XFER;
          beat_d  = '0;
        end
      end
      MISS_XFER: begin
        if (bus.mem_beat) begin
          if (beat_q == BEAT_LAST) begin
            state_d = SYNC;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      SYNC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    active  = (state_d == ACCESS) || (state_d == MISS_REQ) ||
              (state_d == MISS_XFER) || (state_d == SYNC);
    rd_d    = active && !op_d;
    wr_d    = active && op_d;
    rowid_d = active ? row_d : '0;
    sync_d  = (state_d == SYNC);
    mreq_d  = (state_d == MISS_REQ);
    mwr_d   = mreq_d && op_d;
    mrow_d  = mreq_d ? row_d : '0;
    done_d  = '0;
    if (state_d == DONE) done_d[idx_d] = 1'b1;
  end

  assign bus.RD        = rd_q;
  assign bus.WR        = wr_q;
  assign bus.RowId     = rowid_q;
  assign bus.sync      = sync_q;
  assign bus.mem_req   = mreq_q;
  assign bus.mem_wr    = mwr_q;
  assign bus.mem_row   = mrow_q;
  assign bus.req_done  = done_q;
  assign bus.last_slot = slot_q;

`ifdef ROWCACHE_STATS_EN
  logic [15:0] hit_q, misscnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q     <= '0;
      misscnt_q <= '0;
    end else if (state_q == DONE) begin
      if (miss_q) begin
        if (misscnt_q != '1) misscnt_q <= misscnt_q + 16'd1;
      end else begin
        if (hit_q != '1) hit_q <= hit_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = misscnt_q;
`endif

endmodule

// File: tb/tb_rowcache_ctrl.sv
// Self-checking bench for rowcache_ctrl: table of single transactions with a
// scoreboard, plus hand-written reset-mid-transfer and round-robin sequences.
module tb_rowcache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rowcache_ctrl_if #(.NREQ(4), .ADDRWIDTH(17), .CHWIDTH(5)) bus ();

`ifdef ROWCACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  rowcache_ctrl #(
    .NREQ(4), .ADDRWIDTH(17), .CHWIDTH(5), .ACC_CYCLES(3), .XFERBEATS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ROWCACHE_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [16:0] row;
    int          hold_at;     // access cycle (1..3) with hold high, 0 = none
    int          idle_beats;  // stray mem_beat pulses sent while idle
    logic [4:0]  slot;
    logic [3:0]  exp_done;
    logic        exp_wr;
    logic        exp_miss;
  } vec_t;

  typedef struct {
    logic [3:0]  done;
    logic        wr;
    logic [16:0] row;
    logic        miss;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [8:0] outs_vec();
    return {bus.RD, bus.WR, bus.sync, bus.mem_req, bus.mem_wr,
            |bus.RowId, |bus.mem_row, |bus.req_done, |bus.last_slot};
  endfunction

  task automatic idle_inputs();
    bus.req_rd = '0; bus.req_wr = '0; bus.req_row = '0; bus.hold = 1'b0;
    bus.cRowId = '0; bus.mem_ack = 1'b0; bus.mem_beat = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e;
    int acc, mreq_cycles, beats, xfer_cyc, last_beat_cyc, sync_cyc, sync_n;
    int first_mreq_cyc, done_cyc;
    bit saw_rd, saw_wr, saw_mreq, mwr_bad, mrow_bad, row_bad, mreq_after_ack;
    bit strobe_lost, sync_strobe_bad, acked, done, in_xfer;
    logic [3:0] done_seen;
    acc = 0; mreq_cycles = 0; beats = 0; xfer_cyc = 0; last_beat_cyc = -9;
    sync_cyc = -9; sync_n = 0; first_mreq_cyc = -1; done_cyc = -1;
    saw_rd = 0; saw_wr = 0; saw_mreq = 0; mwr_bad = 0; mrow_bad = 0; row_bad = 0;
    mreq_after_ack = 0; strobe_lost = 0; sync_strobe_bad = 0; acked = 0; done = 0;
    done_seen = '0;
    for (int i = 0; i < v.idle_beats; i++) begin
      bus.mem_beat = 1'b1;
      @(negedge clk);
      bus.mem_beat = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (v.rd[i] || v.wr[i]) bus.req_row[i*17 +: 17] = v.row;
      else                    bus.req_row[i*17 +: 17] = 17'($urandom);
    end
    bus.req_rd = v.rd;
    bus.req_wr = v.wr;
    bus.cRowId = v.slot ^ 5'h1F;
    sb.push_back('{done: v.exp_done, wr: v.exp_wr, row: v.row, miss: v.exp_miss});
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_beat = 1'b0;
      in_xfer = acked && !bus.mem_req && !bus.sync && (bus.req_done == '0) && (sync_n == 0);
      if (bus.RD || bus.WR) begin
        acc++;
        saw_rd |= bus.RD;
        saw_wr |= bus.WR;
        if (bus.RowId !== v.row) row_bad = 1;
        bus.req_rd = '0;
        bus.req_wr = '0;
      end
      bus.hold   = (bus.RD || bus.WR) && (v.hold_at != 0) && (acc == v.hold_at);
      bus.cRowId = ((bus.RD || bus.WR) && acc == 3) ? v.slot : v.slot ^ 5'h1F;
      if (bus.mem_req) begin
        if (!saw_mreq) first_mreq_cyc = cyc;
        saw_mreq = 1;
        mreq_cycles++;
        if (bus.mem_wr !== v.exp_wr) mwr_bad = 1;
        if (bus.mem_row !== v.row) mrow_bad = 1;
        if (acked) mreq_after_ack = 1;
        if (mreq_cycles == 2) begin
          bus.mem_ack = 1'b1;
          acked = 1;
        end
      end
      if (in_xfer) begin
        if (!(bus.RD || bus.WR)) strobe_lost = 1;
        if (beats < 8 && (xfer_cyc % 2) == 0) begin
          bus.mem_beat = 1'b1;
          beats++;
          if (beats == 8) last_beat_cyc = cyc;
        end
        xfer_cyc++;
      end
      if (bus.sync) begin
        sync_n++;
        sync_cyc = cyc;
        if (!(bus.RD || bus.WR)) sync_strobe_bad = 1;
      end
      if (bus.req_done != '0) begin
        done_seen = bus.req_done;
        done_cyc = cyc;
        done = 1;
      end
    end
    bus.hold = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_beat = 1'b0;
    bus.req_rd = '0;
    bus.req_wr = '0;
    e = sb.pop_front();
    check("txn_done_seen", done, 1);
    check("req_done", done_seen, e.done);
    check("op_wr", saw_wr, e.wr);
    check("op_rd", saw_rd, !e.wr);
    check("rowid_bad", row_bad, 0);
    check("missed", saw_mreq, e.miss);
    check("last_slot", bus.last_slot, v.slot);
    if (e.miss) begin
      check("mreq_start_cyc", first_mreq_cyc, 3);
      check("mreq_until_ack", mreq_cycles, 2);
      check("mreq_after_ack", mreq_after_ack, 0);
      check("mem_wr_bad", mwr_bad, 0);
      check("mem_row_bad", mrow_bad, 0);
      check("beats", beats, 8);
      check("strobe_in_xfer", strobe_lost, 0);
      check("sync_count", sync_n, 1);
      check("sync_after_beat", sync_cyc - last_beat_cyc, 1);
      check("sync_strobe_bad", sync_strobe_bad, 0);
      check("done_after_sync", done_cyc - sync_cyc, 1);
      exp_misses++;
    end else begin
      check("hit_latency", done_cyc, 3);
      check("hit_strobe_cycles", acc, 3);
      check("hit_sync_count", sync_n, 0);
      exp_hits++;
    end
    @(negedge clk);
    check("req_done_pulse", bus.req_done, 0);
`ifdef ROWCACHE_STATS_EN
    check("hit_cnt", hit_cnt, exp_hits);
    check("miss_cnt", miss_cnt, exp_misses);
`endif
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v_after;
    exp_t e;
    int acked, beats, got, prev;

    vecs[0] = '{rd: 4'b0010, wr: 4'b0000, row: 17'h1A2B3, hold_at: 0, idle_beats: 0,
                slot: 5'h03, exp_done: 4'b0010, exp_wr: 1'b0, exp_miss: 1'b0};
    vecs[1] = '{rd: 4'b0000, wr: 4'b0001, row: 17'h0F00F, hold_at: 3, idle_beats: 0,
                slot: 5'h11, exp_done: 4'b0001, exp_wr: 1'b1, exp_miss: 1'b1};
    vecs[2] = '{rd: 4'b1000, wr: 4'b1000, row: 17'h15555, hold_at: 0, idle_beats: 2,
                slot: 5'h1E, exp_done: 4'b1000, exp_wr: 1'b1, exp_miss: 1'b0};
    vecs[3] = '{rd: 4'b0100, wr: 4'b0000, row: 17'h00001, hold_at: 1, idle_beats: 3,
                slot: 5'h07, exp_done: 4'b0100, exp_wr: 1'b0, exp_miss: 1'b1};
    vecs[4] = '{rd: 4'b0000, wr: 4'b0010, row: 17'h1FFFF, hold_at: 2, idle_beats: 0,
                slot: 5'h1F, exp_done: 4'b0010, exp_wr: 1'b1, exp_miss: 1'b1};
    vecs[5] = '{rd: 4'b0001, wr: 4'b0000, row: 17'h00000, hold_at: 0, idle_beats: 0,
                slot: 5'h00, exp_done: 4'b0001, exp_wr: 1'b0, exp_miss: 1'b0};
    v_after = '{rd: 4'b0100, wr: 4'b0000, row: 17'h0C0DE, hold_at: 0, idle_beats: 0,
                slot: 5'h0A, exp_done: 4'b0100, exp_wr: 1'b0, exp_miss: 1'b0};

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
`ifdef ROWCACHE_STATS_EN
    check("reset_hit_cnt", hit_cnt, 0);
    check("reset_miss_cnt", miss_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Write miss interrupted by reset after four transfer beats.
    acked = 0;
    beats = 0;
    bus.cRowId = 5'h15;
    bus.req_row[0 +: 17] = 17'h0ABCD;
    bus.req_wr = 4'b0001;
    for (int c = 0; c < 60 && beats < 4; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_beat = 1'b0;
      if (bus.RD || bus.WR) bus.req_wr = '0;
      bus.hold = (acked == 0) && !bus.mem_req && (bus.RD || bus.WR);
      if (bus.mem_req && acked == 0) begin
        bus.mem_ack = 1'b1;
        acked = 1;
      end else if (acked != 0 && !bus.mem_req) begin
        bus.mem_beat = 1'b1;
        beats++;
      end
    end
    @(negedge clk);
    bus.mem_beat = 1'b0;
    bus.hold = 1'b0;
    check("rst_seq_beats", beats, 4);
    check("pre_rst_WR", bus.WR, 1);
    check("pre_rst_slot", bus.last_slot, 5'h15);
    rst = 1'b1;
    #1;
    check("mid_xfer_reset_outputs", outs_vec(), 0);
    exp_hits = 0;
    exp_misses = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(v_after);

    // All four requesters reading continuously from a fresh round-robin pointer.
    apply_reset();
    for (int i = 0; i < 4; i++) bus.req_row[i*17 +: 17] = 17'h100 + 17'(i);
    bus.req_rd = 4'hF;
    sb.push_back('{done: 4'b0001, wr: 1'b0, row: 17'h100, miss: 1'b0});
    sb.push_back('{done: 4'b0010, wr: 1'b0, row: 17'h101, miss: 1'b0});
    sb.push_back('{done: 4'b0100, wr: 1'b0, row: 17'h102, miss: 1'b0});
    sb.push_back('{done: 4'b1000, wr: 1'b0, row: 17'h103, miss: 1'b0});
    sb.push_back('{done: 4'b0001, wr: 1'b0, row: 17'h100, miss: 1'b0});
    got = 0;
    prev = 0;
    for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
      @(negedge clk);
      if (bus.req_done != '0) begin
        e = sb.pop_front();
        check("rr_grant", bus.req_done, e.done);
        if (got > 0) check("rr_spacing", cyc - prev, 5);
        prev = cyc;
        got++;
        exp_hits++;
        if (got == 5) bus.req_rd = '0;
      end
    end
    check("rr_all_done", got, 5);
    @(negedge clk);
    check("rr_idle_after", outs_vec(), 9'b000000001 & outs_vec());
`ifdef ROWCACHE_STATS_EN
    check("rr_hit_cnt", hit_cnt, exp_hits);
    check("rr_miss_cnt", miss_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rowcache_ctrl.md
# rowcache_ctrl

Sequencer and arbiter for the shared DRAM row cache. It takes row read/write requests from up to NREQ bank FSMs and grants them round-robin onto the cache's single RD/WR/RowId port. On a miss (cache asserts `hold`) it runs a fill/writeback transfer against the backing row store and closes the access with a one-cycle `sync` pulse. Sits between the per-bank DDR FSMs and the row cache.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `ADDRWIDTH`, 17: row address width.
- `CHWIDTH`, 5: cache row index width.
- `ACC_CYCLES`, 3: cycles RD/WR is held per cache access.
- `XFERBEATS`, 8: backing-store beats per row transfer (1..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_rd` in NREQ: per-requester read request, level.
- `req_wr` in NREQ: per-requester write request, level.
- `req_row` in NREQ*ADDRWIDTH: row address; requester i occupies slice [i*ADDRWIDTH +: ADDRWIDTH].
- `req_done` out NREQ: one-cycle completion pulse for the served requester.
- `RD` out 1: cache read strobe.
- `WR` out 1: cache write strobe.
- `RowId` out ADDRWIDTH: row address to cache.
- `hold` in 1: cache miss/stall indication.
- `cRowId` in CHWIDTH: cache slot in use; latched into `last_slot`.
- `last_slot` out CHWIDTH: `cRowId` captured in the final ACCESS cycle.
- `sync` out 1: transfer-complete pulse to cache.
- `mem_req` out 1: backing-store transfer request.
- `mem_wr` out 1: 1 = writeback (write miss), 0 = fill (read miss); valid while `mem_req` is high.
- `mem_row` out ADDRWIDTH: row for the transfer.
- `mem_ack` in 1: accepts `mem_req`.
- `mem_beat` in 1: one transfer beat completed.

## Operation
- States: IDLE, ACCESS, MISS_REQ, MISS_XFER, SYNC, DONE.
- IDLE: a requester is pending if `req_rd[i] | req_wr[i]`. Pick the first pending index searching upward from `rr_ptr`, mod NREQ. Latch the index, the op (WR if `req_wr[i]`, so write wins over a simultaneous read), and `req_row[i]`. Set `rr_ptr` = index+1 mod NREQ. Go to ACCESS. With nothing pending, stay in IDLE.
- ACCESS: drive `RD` or `WR` with latched `RowId` for ACC_CYCLES cycles.
  - If `hold` is sampled high in any of these cycles, including the last, go to MISS_REQ after the window.
  - Otherwise go to DONE.
- MISS_REQ: keep `RD`/`WR` and `RowId` asserted. Assert `mem_req`, `mem_row`=RowId, `mem_wr`=op. `mem_req` stays high until the cycle `mem_ack` is sampled high, then go to MISS_XFER.
- MISS_XFER: `RD`/`WR` stay asserted. Count `mem_beat` pulses with an 8-bit counter. After beat XFERBEATS, go to SYNC. `mem_beat` outside MISS_XFER is ignored.
- SYNC: `sync`=1 for exactly one cycle with `RD`/`WR` still asserted, then go to DONE.
- DONE: `RD`=`WR`=0, pulse `req_done[idx]`, return to IDLE.
- Requests are re-sampled only in IDLE. A request dropped mid-service still receives `req_done`. A requester still asserting after `req_done` is re-arbitrated behind the others.
- `hold` falling during MISS_REQ/MISS_XFER has no effect; the transfer always completes.

## Timing
- Reset (async, any state) forces:
  - state IDLE, `rr_ptr`=0, beat counter 0;
  - all outputs 0: `RD`, `WR`, `RowId`, `sync`, `mem_req`, `mem_wr`, `mem_row`, `req_done`, `last_slot`.
- Hit latency: request sampled at cycle 0; `RD`/`WR` high cycles 1..ACC_CYCLES; `req_done` at cycle ACC_CYCLES+1; next grant sampled at cycle ACC_CYCLES+2. Hit period is ACC_CYCLES+2 cycles (5 by default).
- Miss latency:
  - `mem_req` rises in the cycle after the ACCESS window.
  - MISS_XFER starts in the cycle after `mem_ack`.
  - `sync` is high in the cycle after the XFERBEATS-th beat.
  - `req_done` follows one cycle after `sync`.
- All outputs are registered. `req_done` is one-hot or zero.

## Configuration
- `ROWCACHE_STATS_EN` defined: adds outputs `hit_cnt` and `miss_cnt`, 16 bits each.
  - Each increments in DONE according to whether the access missed.
  - Both saturate at 0xFFFF and clear on `rst`.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset mid-MISS_XFER (beat 4 of 8): all outputs 0 in the same cycle. After release, a req_rd[2] hit is granted normally.
- Single read hit: `req_rd[1]`=1, row 0x1A2B3, `hold`=0. Required: `RD`=1 with RowId 0x1A2B3 for 3 cycles, then `req_done`=4'b0010 one cycle later, `mem_req` never asserted.
- Write miss: `req_wr[0]`, `hold`=1 in access cycle 3. Required:
  - `mem_req`=1 and `mem_wr`=1 until `mem_ack`;
  - 8 `mem_beat` pulses, then `sync` one cycle with `WR` still 1;
  - then `req_done`=4'b0001;
  - STATS build: `miss_cnt`=1.
- Round-robin: all four requesters assert `req_rd` continuously. Required: grant order 0,1,2,3,0, with `req_done` pulses 5 cycles apart.
- Simultaneous `req_rd[3]` and `req_wr[3]`: `WR` asserted, `RD` stays 0. `mem_beat` pulses sent while in IDLE leave the beat counter at 0.
